thread_sched: RTL and testbench

Parametrised barrel-thread scheduler that replaces the fixed free-running thread timer in the core. Each cycle it chooses which hardware thread fetches, using round-robin order. It skips threads that are disabled, stalled (for example, waiting on a load) or still in flight. It then carries the issued thread ID down a delay line that matches the pipeline, so IFU, IDU, EXU and WB/register file each read the thread ID that belongs to their stage.

---
 rtl/thread_sched_if.sv | 27 ++
 rtl/thread_sched.sv | 95 +++++++++
 tb/tb_thread_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/thread_sched_if.sv
// Scheduler bus: thread enables and stall pulses in, fetch slot and stage thread IDs out.
// The master drives enables/stalls; the scheduler is the slave.
interface thread_sched_if #(
    parameter int NUM_THREADS = 4,
    parameter int PIPE_DEPTH  = 3
);
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    logic [NUM_THREADS-1:0]      thread_en;
    logic [NUM_THREADS-1:0]      stall_set;
    logic [NUM_THREADS-1:0]      stall_clr;
    logic                        fetch_valid;
    logic [TID_W-1:0]            fetch_tid;
    logic [PIPE_DEPTH-1:0]       stage_valid;
    logic [PIPE_DEPTH*TID_W-1:0] stage_tid;
    logic [NUM_THREADS-1:0]      stalled;

    modport master (
        output thread_en, stall_set, stall_clr,
        input  fetch_valid, fetch_tid, stage_valid, stage_tid, stalled
    );

    modport slave (
        input  thread_en, stall_set, stall_clr,
        output fetch_valid, fetch_tid, stage_valid, stage_tid, stalled
    );
endinterface

// File: rtl/thread_sched.sv
// Barrel-thread scheduler: round-robin fetch selection over enabled, unstalled,
// not-in-flight threads, with a thread-ID delay line matching the pipeline stages.
module thread_sched #(
    parameter int NUM_THREADS = 4,
    parameter int PIPE_DEPTH  = 3
) (
    input  logic          clk,
    input  logic          rst,
    thread_sched_if.slave bus
);
    localparam int TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam logic [TID_W-1:0] LAST_TID_RST = TID_W'(NUM_THREADS - 1);

    logic [NUM_THREADS-1:0] stalled_q;
    logic [TID_W-1:0]       last_tid_q;
    logic                   fetch_valid_q;
    logic [TID_W-1:0]       fetch_tid_q;
    logic [PIPE_DEPTH-1:0]  stage_valid_q;
    logic [TID_W-1:0]       stage_tid_q [PIPE_DEPTH];

    logic [NUM_THREADS-1:0] inflight;
    logic [NUM_THREADS-1:0] eligible;
    logic                   sel_found;
    logic [TID_W-1:0]       sel_tid;

    // The last stage retires this cycle, so it does not block its thread.
    always_comb begin
        inflight = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            if (fetch_valid_q && fetch_tid_q == TID_W'(t))
                inflight[t] = 1'b1;
            for (int s = 0; s < PIPE_DEPTH - 1; s++) begin
                if (stage_valid_q[s] && stage_tid_q[s] == TID_W'(t))
                    inflight[t] = 1'b1;
            end
        end
    end

    assign eligible = bus.thread_en & ~stalled_q & ~inflight;

    // Walk farthest-first so the nearest eligible thread after last_tid wins.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_tid   = last_tid_q;
        idx       = 0;
        for (int k = NUM_THREADS; k >= 1; k--) begin
            idx = int'(last_tid_q) + k;
            if (idx >= NUM_THREADS)
                idx = idx - NUM_THREADS;
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (t == idx && eligible[t]) begin
                    sel_found = 1'b1;
                    sel_tid   = TID_W'(t);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stalled_q     <= '0;
            last_tid_q    <= LAST_TID_RST;
            fetch_valid_q <= 1'b0;
            fetch_tid_q   <= '0;
            stage_valid_q <= '0;
            for (int s = 0; s < PIPE_DEPTH; s++)
                stage_tid_q[s] <= '0;
        end else begin
            stalled_q     <= (stalled_q & ~bus.stall_clr) | bus.stall_set;
            fetch_valid_q <= sel_found;
            if (sel_found) begin
                fetch_tid_q <= sel_tid;
                last_tid_q  <= sel_tid;
            end
            stage_valid_q[0] <= fetch_valid_q;
            stage_tid_q[0]   <= fetch_tid_q;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                stage_valid_q[s] <= stage_valid_q[s-1];
                stage_tid_q[s]   <= stage_tid_q[s-1];
            end
        end
    end

    always_comb begin
        bus.stage_tid = '0;
        for (int s = 0; s < PIPE_DEPTH; s++)
            bus.stage_tid[s*TID_W +: TID_W] = stage_tid_q[s];
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_tid   = fetch_tid_q;
    assign bus.stage_valid = stage_valid_q;
    assign bus.stalled     = stalled_q;
endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: vector table on a 4-thread/3-stage instance,
// plus hand sequences for 3/1 and 5/3 wrap and asynchronous reset.
module tb_thread_sched;
    logic clk;
    logic rst;

    thread_sched_if #(.NUM_THREADS(4), .PIPE_DEPTH(3)) bus4 ();
    thread_sched_if #(.NUM_THREADS(3), .PIPE_DEPTH(1)) bus3 ();
    thread_sched_if #(.NUM_THREADS(5), .PIPE_DEPTH(3)) bus5 ();

    thread_sched #(.NUM_THREADS(4), .PIPE_DEPTH(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    thread_sched #(.NUM_THREADS(3), .PIPE_DEPTH(1)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    thread_sched #(.NUM_THREADS(5), .PIPE_DEPTH(3)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst_before;
        logic [3:0] en;
        logic [3:0] set;
        logic [3:0] clr;
        logic       fv;
        logic [1:0] ft;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic       e_sv [3];
    logic [1:0] e_st [3];
    logic       p_fv;
    logic [1:0] p_ft;

    function automatic vec_t mk(bit r, logic [3:0] en, logic [3:0] set, logic [3:0] clr,
                                logic fv, logic [1:0] ft, logic [3:0] st);
        vec_t v;
        v.rst_before = r; v.en = en; v.set = set; v.clr = clr;
        v.fv = fv; v.ft = ft; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 3; s++) begin
            e_sv[s] = 1'b0;
            e_st[s] = 2'd0;
        end
        p_fv = 1'b0;
        p_ft = 2'd0;
    endtask

    // Assert reset a few ns after an edge, release on the falling edge.
    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    initial begin
        rst = 1'b0;
        bus4.thread_en = 4'b1111; bus4.stall_set = '0; bus4.stall_clr = '0;
        bus3.thread_en = 3'b111;  bus3.stall_set = '0; bus3.stall_clr = '0;
        bus5.thread_en = 5'b11111; bus5.stall_set = '0; bus5.stall_clr = '0;
        clear_model();

        // all enabled: 0,1,2,3,0,1
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 3, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000));
        // en=0101: 0,2,b,b,0,2 (bubble holds tid)
        vecs.push_back(mk(1, 4'b0101, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 1, 2, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 0, 2, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 0, 2, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0101, 4'b0000, 4'b0000, 1, 2, 4'b0000));
        // en=0001: 0,b,b,b,0
        vecs.push_back(mk(1, 4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        // stall thread 1 while it sits in fetch, later clear it
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0010, 4'b0000, 1, 2, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 3, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 3, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0010, 1, 2, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 3, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 4'b0000));
        // set and clear together on thread 2: set wins; clear alone later releases
        vecs.push_back(mk(1, 4'b1111, 4'b0100, 4'b0100, 1, 0, 4'b0100));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0100));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0100, 1, 3, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 4'b0000));
        // all disabled holds last_tid: resumes after 1 with 2
        vecs.push_back(mk(1, 4'b1111, 4'b0000, 4'b0000, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000));
        vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 1, 2, 4'b0000));

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) begin
                do_reset();
                chk("reset_fetch_valid", int'(bus4.fetch_valid), 0);
                chk("reset_stalled", int'(bus4.stalled), 0);
            end
            bus4.thread_en = vecs[i].en;
            bus4.stall_set = vecs[i].set;
            bus4.stall_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            bus4.stall_set = '0;
            bus4.stall_clr = '0;
            for (int s = 2; s >= 1; s--) begin
                e_sv[s] = e_sv[s-1];
                e_st[s] = e_st[s-1];
            end
            e_sv[0] = p_fv;
            e_st[0] = p_ft;
            p_fv = vecs[i].fv;
            p_ft = vecs[i].ft;
            chk($sformatf("v%0d fetch_valid", i), int'(bus4.fetch_valid), int'(vecs[i].fv));
            chk($sformatf("v%0d fetch_tid", i), int'(bus4.fetch_tid), int'(vecs[i].ft));
            chk($sformatf("v%0d stalled", i), int'(bus4.stalled), int'(vecs[i].st));
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("v%0d stage%0d_valid", i, s), int'(bus4.stage_valid[s]), int'(e_sv[s]));
                chk($sformatf("v%0d stage%0d_tid", i, s), int'(bus4.stage_tid[s*2 +: 2]), int'(e_st[s]));
            end
        end

        // 3 threads / depth 1 and 5 threads / depth 3, all enabled
        bus4.thread_en = 4'b1111;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("n3 k%0d fetch_valid", k), int'(bus3.fetch_valid), 1);
            chk($sformatf("n3 k%0d fetch_tid", k), int'(bus3.fetch_tid), k % 3);
            chk($sformatf("n3 k%0d stage0_valid", k), int'(bus3.stage_valid[0]), (k > 0) ? 1 : 0);
            chk($sformatf("n3 k%0d stage0_tid", k), int'(bus3.stage_tid), (k > 0) ? (k - 1) % 3 : 0);
            chk($sformatf("n5 k%0d fetch_valid", k), int'(bus5.fetch_valid), 1);
            chk($sformatf("n5 k%0d fetch_tid", k), int'(bus5.fetch_tid), k % 5);
            chk($sformatf("n5 k%0d wb_tid", k), int'(bus5.stage_tid[2*3 +: 3]), (k >= 3) ? (k - 3) % 5 : 0);
        end

        // asynchronous reset mid-run with a stall pending and slots full
        do_reset();
        @(posedge clk); #1;
        bus4.stall_set = 4'b0100;
        @(posedge clk); #1;
        bus4.stall_set = '0;
        @(posedge clk); #1;
        chk("pre_rst stalled", int'(bus4.stalled), 4);
        chk("pre_rst stage_valid", int'(bus4.stage_valid), 3'b011);
        #2 rst = 1'b0;
        #1;
        chk("async fetch_valid", int'(bus4.fetch_valid), 0);
        chk("async fetch_tid", int'(bus4.fetch_tid), 0);
        chk("async stage_valid", int'(bus4.stage_valid), 0);
        chk("async stage_tid", int'(bus4.stage_tid), 0);
        chk("async stalled", int'(bus4.stalled), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst fetch_valid", int'(bus4.fetch_valid), 1);
        chk("post_rst fetch_tid", int'(bus4.fetch_tid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
